// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bit positions,
// payload sizing and the occupancy state encoding.
package ex_mem_pipe_pkg;

    // Bit positions inside the 4-bit control bundle {RegWrite, MemRead, MemWrite, Branch}
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 0;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Bundled fields: result, target, store data, dest reg, zero flag, 4 control bits
    localparam int PAYLOAD_W = DATA_W_DEF * 3 + REG_ADDR_W_DEF + 5;

    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return data_w * 3 + reg_addr_w + 5;
    endfunction

    // Encoded as {skid_valid, main_valid}; 2'b10 cannot occur
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

endpackage

// File: rtl/ex_mem_slot.sv
// Single payload register with load enable. Used twice by ex_mem_pipe,
// once as the main (output-facing) entry and once as the skid entry.
module ex_mem_slot #(
    parameter int W = ex_mem_pipe_pkg::PAYLOAD_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the payload on load, hold otherwise
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the data register is reset because its value is visible on the
        // stage outputs straight after reset; non-blocking keeps edge semantics.
        if (!rst_i) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage with a 2-entry skid buffer (main + skid) so that
// in_ready_o is a flop and never depends combinationally on out_ready_i.
// Optional build macro EXMEM_PERF_EN adds a saturating stall counter.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic                  alu_zero_i,
    input  logic [REG_ADDR_W-1:0] wr_reg_i,
    input  logic [3:0]            ctrl_i,
    input  logic [DATA_W-1:0]     branch_tgt_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic                  alu_zero_o,
    output logic [REG_ADDR_W-1:0] wr_reg_o,
    output logic [3:0]            ctrl_o,
    output logic [DATA_W-1:0]     branch_tgt_o,
    output logic [DATA_W-1:0]     wdata_o,
`ifdef EXMEM_PERF_EN
    output logic [31:0]           stall_cnt_o,
`endif
    output logic                  branch_taken_o
);

    localparam int PW = payload_w(DATA_W, REG_ADDR_W);

    state_e          state_q;
    logic            in_ready_q;
    logic            in_xfer;
    logic            out_xfer;
    logic            main_load;
    logic            skid_load;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   main_d;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;

    assign in_payload  = {alu_result_i, alu_zero_i, wr_reg_i, ctrl_i, branch_tgt_i, wdata_i};
    assign out_valid_o = state_q[0];
    assign in_ready_o  = in_ready_q;
    assign in_xfer     = in_valid_i & in_ready_q;
    assign out_xfer    = out_valid_o & out_ready_i;

    // Decide which slot loads this cycle; flush suppresses all loads so the
    // data registers keep their old contents
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_payload;
        if (!flush_i) begin
            case (state_q)
                ST_EMPTY: main_load = in_xfer;
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    main_load = out_xfer;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end
    end

    // Occupancy state and the registered ready (complement of next skid_valid)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) state_q <= ST_ONE;
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    ex_mem_slot #(.W(PW)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    ex_mem_slot #(.W(PW)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
    );

    assign {alu_result_o, alu_zero_o, wr_reg_o, ctrl_o, branch_tgt_o, wdata_o} = main_q;

    assign branch_taken_o = out_valid_o & ctrl_o[CTRL_BRANCH] & alu_zero_o;

`ifdef EXMEM_PERF_EN
    // Count cycles where MEM back-pressures a valid entry; saturates, ignores flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && stall_cnt_o != 32'hFFFF_FFFF) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: the model is an in-order queue of
// accepted instructions with capacity 2; a monitor on the falling edge
// compares the DUT against the queue front and then advances the model.
module tb_ex_mem_pipe;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] wd;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic [4:0]  wr_reg_i;
    logic [3:0]  ctrl_i;
    logic [31:0] branch_tgt_i;
    logic [31:0] wdata_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result_o;
    logic        alu_zero_o;
    logic [4:0]  wr_reg_o;
    logic [3:0]  ctrl_o;
    logic [31:0] branch_tgt_o;
    logic [31:0] wdata_o;
    logic        branch_taken;
`ifdef EXMEM_PERF_EN
    logic [31:0] stall_cnt;
    int unsigned stall_m;
`endif

    item_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    bit    done    = 0;

    ex_mem_pipe dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .alu_result_i   (alu_result_i),
        .alu_zero_i     (alu_zero_i),
        .wr_reg_i       (wr_reg_i),
        .ctrl_i         (ctrl_i),
        .branch_tgt_i   (branch_tgt_i),
        .wdata_i        (wdata_i),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .alu_result_o   (alu_result_o),
        .alu_zero_o     (alu_zero_o),
        .wr_reg_o       (wr_reg_o),
        .ctrl_o         (ctrl_o),
        .branch_tgt_o   (branch_tgt_o),
        .wdata_o        (wdata_o),
`ifdef EXMEM_PERF_EN
        .stall_cnt_o    (stall_cnt),
`endif
        .branch_taken_o (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), return 2ns after the next edge
    task automatic cyc(input logic v, input logic [31:0] res, input logic z, input logic [3:0] c,
                       input logic [31:0] tgt, input logic rdy, input logic fl);
        in_valid     = v;
        alu_result_i = res;
        alu_zero_i   = z;
        ctrl_i       = c;
        branch_tgt_i = tgt;
        wr_reg_i     = res[4:0] ^ 5'h15;
        wdata_i      = ~res;
        out_ready    = rdy;
        flush        = fl;
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare against the model, then apply this cycle's transfers to it
    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                sb.delete();
`ifdef EXMEM_PERF_EN
                stall_m = 0;
`endif
            end else begin
                bit    acc_in;
                bit    acc_out;
                item_t it;
                check("in_ready", in_ready, sb.size() < 2);
                check("out_valid", out_valid, sb.size() > 0);
                if (sb.size() > 0) begin
                    check("alu_result", alu_result_o, sb[0].res);
                    check("alu_zero", alu_zero_o, sb[0].z);
                    check("wr_reg", wr_reg_o, sb[0].rd);
                    check("ctrl", ctrl_o, sb[0].ctrl);
                    check("branch_tgt", branch_tgt_o, sb[0].tgt);
                    check("wdata", wdata_o, sb[0].wd);
                    check("branch_taken", branch_taken, sb[0].ctrl[0] & sb[0].z);
                end else begin
                    check("branch_taken_idle", branch_taken, 1'b0);
                end
`ifdef EXMEM_PERF_EN
                check("stall_cnt", stall_cnt, stall_m);
                if (sb.size() > 0 && !out_ready) stall_m++;
`endif
                acc_in  = in_valid && (sb.size() < 2);
                acc_out = (sb.size() > 0) && out_ready;
                if (flush) begin
                    sb.delete();
                end else begin
                    if (acc_out) void'(sb.pop_front());
                    if (acc_in) begin
                        it.res  = alu_result_i;
                        it.z    = alu_zero_i;
                        it.rd   = wr_reg_i;
                        it.ctrl = ctrl_i;
                        it.tgt  = branch_tgt_i;
                        it.wd   = wdata_i;
                        sb.push_back(it);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_alu_result", alu_result_o, 32'h0);
        rst_n = 1'b1;

        // Pass-through at full rate
        cyc(1, 32'h5, 0, 4'b1000, 32'h100, 1, 0);
        check("pt_res0", alu_result_o, 32'h5);
        cyc(1, 32'hA, 0, 4'b1000, 32'h104, 1, 0);
        check("pt_res1", alu_result_o, 32'hA);
        cyc(1, 32'hF, 0, 4'b1000, 32'h108, 1, 0);
        check("pt_res2", alu_result_o, 32'hF);
        check("pt_ready", in_ready, 1'b1);
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);

        // Back-pressure fills main then skid
        cyc(1, 32'h11, 0, 4'b0100, 32'h0, 0, 0);
        cyc(1, 32'h22, 0, 4'b0010, 32'h0, 0, 0);
        check("bp_ready_low", in_ready, 1'b0);
        check("bp_hold", alu_result_o, 32'h11);
        cyc(1, 32'h99, 0, 4'b0010, 32'h0, 1, 0);
        check("bp_second", alu_result_o, 32'h22);
        check("bp_ready_back", in_ready, 1'b1);
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);

        // Branch taken / not taken
        cyc(1, 32'h0, 1, 4'b0001, 32'h40, 1, 0);
        check("br_taken", branch_taken, 1'b1);
        check("br_tgt", branch_tgt_o, 32'h40);
        cyc(1, 32'h7, 0, 4'b0001, 32'h40, 1, 0);
        check("br_not_taken", branch_taken, 1'b0);
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);

        // Flush in state ONE with a simultaneous input
        cyc(1, 32'h44, 0, 4'h0, 32'h0, 0, 0);
        cyc(1, 32'h33, 0, 4'h0, 32'h0, 0, 1);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        repeat (3) cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);

`ifdef EXMEM_PERF_EN
        // Seven stalled cycles with a held entry (counter also carries earlier stalls)
        begin
            logic [31:0] base;
            cyc(1, 32'h55, 0, 4'h0, 32'h0, 0, 0);
            base = stall_m;
            repeat (7) cyc(0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
            check("perf_stall7", stall_cnt - base, 32'd7);
            cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end

        // Reset asserted mid-cycle while FULL
        cyc(1, 32'hAA, 0, 4'h0, 32'h0, 0, 0);
        cyc(1, 32'hBB, 0, 4'h0, 32'h0, 0, 0);
        cyc(1, 32'hCC, 0, 4'h0, 32'h0, 0, 0);
        check("mid_full", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_result", alu_result_o, 32'h0);
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);
        rst_n = 1'b1;
        cyc(1, 32'h123, 1, 4'b0001, 32'h80, 1, 0);
        check("post_rst_result", alu_result_o, 32'h123);
        repeat (4) cyc(0, 32'h0, 0, 4'h0, 32'h0, 1, 0);

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Execute-to-memory pipeline stage. Sits directly downstream of the ALU and captures result_o/zero_o plus the control and data that travel with each instruction.
- Decouples EX from MEM with a valid/ready handshake and a 2-entry skid buffer, so back-pressure from MEM never creates a combinational ready path into EX.
- Produces the registered branch-taken decision consumed by the PC-select logic.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous flush; kills every held entry.
- in_valid_i  input  1  EX presents a valid instruction.
- in_ready_o  output  1  stage can accept; registered.
- alu_result_i  input  DATA_W  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- wr_reg_i  input  REG_ADDR_W  destination register.
- ctrl_i  input  4  {RegWrite, MemRead, MemWrite, Branch}, bit 3 down to bit 0.
- branch_tgt_i  input  DATA_W  computed branch target.
- wdata_i  input  DATA_W  store data (rt value).
- out_valid_o  output  1  MEM-side entry valid.
- out_ready_i  input  1  MEM accepts the entry.
- alu_result_o  output  DATA_W  held ALU result.
- alu_zero_o  output  1  held zero flag.
- wr_reg_o  output  REG_ADDR_W  held destination.
- ctrl_o  output  4  held control.
- branch_tgt_o  output  DATA_W  held target.
- wdata_o  output  DATA_W  held store data.
- branch_taken_o  output  1  out_valid_o & ctrl_o[0] & alu_zero_o.

Behaviour:
- Reset (rst_i low, asynchronous): main and skid valid flags 0, all data registers 0, in_ready_o = 1. Outputs hold these values until the first accepted transfer after reset deasserts.
- Transfer rules:
  - Input transfer occurs when in_valid_i & in_ready_o.
  - Output transfer occurs when out_valid_o & out_ready_i.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00).
  - ONE (01): main holds an entry.
  - FULL (11): main and skid both hold entries.
  - 10 is illegal and unreachable.
- Transitions:
  - EMPTY: on input transfer, load main -> ONE.
  - ONE, input and output together: main <= input, stay ONE.
  - ONE, input only: input goes to skid -> FULL, and in_ready_o drops next cycle.
  - ONE, output only -> EMPTY.
  - FULL, on output transfer: main <= skid -> ONE, in_ready_o returns to 1. No input transfer is possible in FULL.
- in_ready_o is the registered complement of skid_valid.
- Latency: 1 cycle from input transfer to out_valid_o when the stage is empty. Throughput is 1 per cycle while out_ready_i stays high.
- Stability: while out_valid_o & !out_ready_i, every *_o data output is held bit-stable.
- Ordering: entries leave in acceptance order; the skid entry never overtakes main.
- flush_i: at the next edge both valid flags go to 0 and in_ready_o goes to 1. Flush wins over a simultaneous input transfer, which is discarded. Data registers keep their values; only the valid flags clear.
- branch_taken_o is combinational from the held registers and is never 1 while out_valid_o is 0.
- Width rule: no arithmetic is performed; all fields are passed bit-exact.

Optional Feature:
- EXMEM_PERF_EN defined:
  - Adds output stall_cnt_o (32 bits), reset to 0.
  - Increments each cycle that out_valid_o & !out_ready_i, saturating at 32'hFFFF_FFFF.
  - flush_i does not clear it.
- EXMEM_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Control-bit index constants: CTRL_REGWRITE = 3, CTRL_MEMREAD = 2, CTRL_MEMWRITE = 1, CTRL_BRANCH = 0.
  - Payload-width constant for the bundled fields (DATA_W*3 + REG_ADDR_W + 5).
- One sub-module is natural: ex_mem_slot, a single payload register with load enable and async active-low reset. It is instantiated twice, as main and skid.

Test Plan:
- Reset mid-stream: assert rst_i low while FULL -> same cycle out_valid_o = 0, in_ready_o = 1, alu_result_o = 0.
- Pass-through: out_ready_i = 1, inject results 0x5, 0xA, 0xF on consecutive cycles -> identical sequence appears on alu_result_o one cycle later each; in_ready_o stays 1.
- Back-pressure: out_ready_i = 0, inject 0x11 then 0x22 -> FULL, in_ready_o = 0, alu_result_o held at 0x11. Raise out_ready_i -> 0x11 then 0x22 delivered in order.
- Branch: ctrl_i = 4'b0001, alu_zero_i = 1, branch_tgt_i = 0x40 -> next cycle branch_taken_o = 1, branch_tgt_o = 0x40. With alu_zero_i = 0, branch_taken_o = 0.
- Flush with simultaneous input: state ONE, flush_i = 1 and in_valid_i = 1 with 0x33 -> next cycle out_valid_o = 0 and 0x33 is never output.
- With EXMEM_PERF_EN: hold out_ready_i = 0 for 7 cycles with a valid entry -> stall_cnt_o = 7.
